// File: rtl/uart_tx_if.sv
// uart_tx_if: write handshake between the UART register block and the TX stage.
//   tx_data   word to transmit (DATA_BITS wide)
//   tx_valid  tx_data is valid this cycle
//   tx_ready  TX FIFO can accept a word
// Modports: master = register block side, slave = uart_tx side.
interface uart_tx_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter. Words enter a small FIFO through a valid/ready
// handshake and are sent LSB-first as start / data / stop frames, one bit per tick.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset; aborts any frame and empties the FIFO
//   tick   one-clock bit-period strobe from the baud generator
//   bus    slave side of uart_tx_if (tx_data, tx_valid in; tx_ready out = !full)
//   tx     registered serial line, idles high
//   busy   registered; high while a frame is in progress or the FIFO holds data
module uart_tx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      tick,
   uart_tx_if.slave  bus,
   output logic      tx,
   output logic      busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(DATA_BITS);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e               state;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] shreg;
   logic [CW-1:0]        bit_cnt;
   logic                 stop_cnt;

   logic                 empty;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 bit_last;
   logic                 stop_last;
   logic                 next_idle;
   logic [PW-1:0]        wr_ptr_nxt;
   logic [PW-1:0]        rd_ptr_nxt;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign bus.tx_ready = !full;

   // Refused while full even if a pop happens in the same cycle.
   assign push = bus.tx_valid && !full;

   assign bit_last  = (bit_cnt == CW'(DATA_BITS - 1));
   assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

   // Uses the registered empty flag, so a word pushed on this edge cannot start a frame yet.
   assign pop = tick && !empty && ((state == StIdle) || ((state == StStop) && stop_last));

   assign wr_ptr_nxt = wr_ptr + PW'(push);
   assign rd_ptr_nxt = rd_ptr + PW'(pop);

   assign next_idle = ((state == StIdle) && !pop) ||
                      ((state == StStop) && tick && stop_last && !pop);

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= bus.tx_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= StIdle;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         busy   <= !next_idle || (wr_ptr_nxt != rd_ptr_nxt);

         if (tick) begin
            unique case (state)
               StIdle: begin
                  if (pop) begin
                     shreg <= mem[rd_ptr[AW-1:0]];
                     tx    <= 1'b0;
                     state <= StStart;
                  end else begin
                     tx <= 1'b1;
                  end
               end
               StStart: begin
                  tx      <= shreg[0];
                  shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                  bit_cnt <= '0;
                  state   <= StData;
               end
               StData: begin
                  if (bit_last) begin
                     tx       <= 1'b1;
                     stop_cnt <= 1'b0;
                     state    <= StStop;
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
               StStop: begin
                  if (stop_last) begin
                     if (pop) begin
                        // Next word follows immediately; no idle bit between frames.
                        shreg <= mem[rd_ptr[AW-1:0]];
                        tx    <= 1'b0;
                        state <= StStart;
                     end else begin
                        state <= StIdle;
                     end
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx. Instance a is 8N1, instance b is 7 data / 2 stop.
// tick pulses every 4 clocks while tick_en is set, so every bit lasts 4 clocks.
module tb_uart_tx;

   logic clk;
   logic reset;
   logic tick;
   logic tick_en;
   logic tx_a;
   logic busy_a;
   logic tx_b;
   logic busy_b;
   int   tick_div;
   int   total;
   int   bad;

   uart_tx_if #(.DATA_BITS(8)) bus_a ();
   uart_tx_if #(.DATA_BITS(7)) bus_b ();

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .bus   (bus_a),
      .tx    (tx_a),
      .busy  (busy_a)
   );

   uart_tx #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .bus   (bus_b),
      .tx    (tx_b),
      .busy  (busy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick     = 1'b0;
      tick_div = 0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_en && tick_div == 3) begin
            tick     = 1'b1;
            tick_div = 0;
         end else begin
            tick = 1'b0;
            if (tick_en) tick_div = tick_div + 1;
         end
      end
   end

   typedef struct {
      string      name;
      logic [7:0] data;
      logic [9:0] line;   // line[i] = expected tx level in bit period i (0 = start bit)
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [7:0] d);
      bus_a.tx_data  = d;
      bus_a.tx_valid = 1'b1;
      step();
      bus_a.tx_valid = 1'b0;
   endtask

   // Advance until the selected line goes low; an expired budget counts as a failure.
   task automatic wait_fall(input bit sel, input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 24; n++) begin
         step();
         if ((sel ? tx_b : tx_a) == 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_start_seen"}, 32'(seen), 32'd1);
   endtask

   // Called on the first clock of the start bit; returns on the first clock after the frame.
   task automatic check_frame(input bit sel, input string name, input logic [9:0] line,
                              input bit last);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 4; j++) begin
            check($sformatf("%s_bit%0d", name, i), 32'(sel ? tx_b : tx_a), 32'(line[i]));
            if (i == 9 && j == 3) begin
               check({name, "_busy_in_stop"}, 32'(sel ? busy_b : busy_a), 32'd1);
            end
            step();
         end
      end
      check({name, "_busy_after"}, 32'(sel ? busy_b : busy_a), 32'(!last));
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      tick_en        = 1'b0;
      reset          = 1'b1;
      bus_a.tx_data  = '0;
      bus_a.tx_valid = 1'b0;
      bus_b.tx_data  = '0;
      bus_b.tx_valid = 1'b0;

      vecs[0] = '{name: "a5", data: 8'hA5, line: 10'b1101001010};
      vecs[1] = '{name: "3c", data: 8'h3C, line: 10'b1001111000};
      vecs[2] = '{name: "01", data: 8'h01, line: 10'b1000000010};
      vecs[3] = '{name: "80", data: 8'h80, line: 10'b1100000000};

      step();
      step();
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_ready", 32'(bus_a.tx_ready), 32'd1);
      reset = 1'b0;

      // Idle with ticks running: nothing may move.
      tick_en = 1'b1;
      for (int c = 0; c < 100; c++) begin
         check("idle_tx", 32'(tx_a), 32'd1);
         check("idle_busy", 32'(busy_a), 32'd0);
         check("idle_ready", 32'(bus_a.tx_ready), 32'd1);
         step();
      end

      // Single frames from the table.
      for (int v = 0; v < 4; v++) begin
         push_a(vecs[v].data);
         check({vecs[v].name, "_busy_after_push"}, 32'(busy_a), 32'd1);
         wait_fall(1'b0, vecs[v].name);
         check_frame(1'b0, vecs[v].name, vecs[v].line, 1'b1);
         for (int c = 0; c < 8; c++) begin
            check({vecs[v].name, "_line_idle"}, 32'(tx_a), 32'd1);
            step();
         end
      end

      // Fill the FIFO with ticks stopped: 4 accepted, ready low from the 4th push on.
      tick_en = 1'b0;
      step();
      bus_a.tx_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         bus_a.tx_data = 8'(k * 17);
         step();
         check($sformatf("fill_ready%0d", k), 32'(bus_a.tx_ready), 32'(k < 4));
      end
      bus_a.tx_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check("full_tx_hold", 32'(tx_a), 32'd1);
         check("full_busy", 32'(busy_a), 32'd1);
         check("full_ready", 32'(bus_a.tx_ready), 32'd0);
         step();
      end
      tick_en = 1'b1;
      begin
         bit seen;
         seen = 1'b0;
         for (int n = 0; n < 24; n++) begin
            step();
            if (tx_a == 1'b0) begin
               seen = 1'b1;
               break;
            end
            check("ready_before_pop", 32'(bus_a.tx_ready), 32'd0);
         end
         check("fill_start_seen", 32'(seen), 32'd1);
      end
      check("ready_after_pop", 32'(bus_a.tx_ready), 32'd1);
      // Re-present the 5th word while the first frame goes out.
      bus_a.tx_data  = 8'h55;
      bus_a.tx_valid = 1'b1;
      fork
         check_frame(1'b0, "f11", 10'b1000100010, 1'b0);
         begin
            step();
            bus_a.tx_valid = 1'b0;
            check("refill_ready", 32'(bus_a.tx_ready), 32'd0);
         end
      join
      check_frame(1'b0, "f22", 10'b1001000100, 1'b0);
      check_frame(1'b0, "f33", 10'b1001100110, 1'b0);
      check_frame(1'b0, "f44", 10'b1010001000, 1'b0);
      check_frame(1'b0, "f55", 10'b1010101010, 1'b1);

      // Back-to-back 0x00 then 0xFF: 20 periods, no idle bit between.
      push_a(8'h00);
      push_a(8'hFF);
      wait_fall(1'b0, "b2b");
      check_frame(1'b0, "b2b_00", 10'b1000000000, 1'b0);
      check_frame(1'b0, "b2b_ff", 10'b1111111110, 1'b1);
      check("b2b_tail", 32'(tx_a), 32'd1);

      // Reset during data bit 3 of 0x3C (bit period 4).
      push_a(8'h3C);
      wait_fall(1'b0, "rst3c");
      for (int c = 0; c < 18; c++) step();
      check("rst3c_bit3", 32'(tx_a), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rst3c_tx_async", 32'(tx_a), 32'd1);
      check("rst3c_busy", 32'(busy_a), 32'd0);
      step();
      reset = 1'b0;
      for (int c = 0; c < 60; c++) begin
         check("post_rst_tx", 32'(tx_a), 32'd1);
         check("post_rst_busy", 32'(busy_a), 32'd0);
         check("post_rst_ready", 32'(bus_a.tx_ready), 32'd1);
         step();
      end

      // Reset while the start bit is low: line must rise without a clock edge.
      push_a(8'h3C);
      wait_fall(1'b0, "rst_sb");
      check("rst_sb_low", 32'(tx_a), 32'd0);
      #1 reset = 1'b1;
      #1;
      check("rst_sb_tx_async", 32'(tx_a), 32'd1);
      step();
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         check("rst_sb_quiet", 32'(tx_a), 32'd1);
         step();
      end

      // 7 data bits, 2 stop bits: 0x55 -> 0,1,0,1,0,1,0,1,1,1.
      bus_b.tx_data  = 7'h55;
      bus_b.tx_valid = 1'b1;
      step();
      bus_b.tx_valid = 1'b0;
      wait_fall(1'b1, "b55");
      check_frame(1'b1, "b55", 10'b1110101010, 1'b1);
      for (int c = 0; c < 8; c++) begin
         check("b55_idle", 32'(tx_b), 32'd1);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
